// File: rtl/instruction_execute.sv
// tinycpu execute stage: 16x32 register file plus integer ALU behind a DIR/DOR/ack handshake.
// Optional build macro EXEC_FLAGS_EN adds the {carry, zero} flags port and the ADC opcode.
module instruction_execute #(
    parameter int NREGS   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DIR,
    output logic        ack_from_EX,
    input  logic [31:0] data_in,
    output logic        DOR,
    input  logic        ack_to_EX,
    output logic [31:0] data_out,
    output logic [3:0]  result_rd,
    output logic        illegal
`ifdef EXEC_FLAGS_EN
    ,
    output logic [1:0]  flags
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    state_t      state, next_state;
    logic        armed;
    logic [31:0] instr;
    logic [31:0] regs [NREGS];

    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] imm16;
    logic [31:0] op_a, op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [32:0] shr_tmp;
    logic [32:0] res33;
    logic [31:0] result;
    logic        wr_en, keep_rd, bad_op, upd_flags;
    logic        accept;

    assign op    = instr[31:28];
    assign rd    = instr[27:24];
    assign rs1   = instr[23:20];
    assign rs2   = instr[19:16];
    assign imm16 = instr[15:0];

    // r0 is hardwired to zero on the read side; its storage is never written.
    assign op_a    = (rs1 == 4'd0) ? 32'd0 : regs[rs1];
    assign op_b    = (rs2 == 4'd0) ? 32'd0 : regs[rs2];
    assign shamt   = op_b[SHAMT_W-1:0];
    assign shr_tmp = {op_a, 1'b0} >> shamt;
    assign result  = res33[31:0];
    assign accept  = (state == IDLE) && DIR && armed;

    // res33[32] carries the carry/borrow/last-shifted-out bit for flag updates.
    always_comb begin
        res33     = '0;
        wr_en     = 1'b1;
        keep_rd   = 1'b1;
        bad_op    = 1'b0;
        upd_flags = 1'b1;
        case (op)
            4'h0: begin wr_en = 1'b0; keep_rd = 1'b0; upd_flags = 1'b0; end
            4'h1: res33 = {1'b0, op_a} + {1'b0, op_b};
            4'h2: res33 = {1'b0, op_a} - {1'b0, op_b};
            4'h3: res33 = {1'b0, op_a & op_b};
            4'h4: res33 = {1'b0, op_a | op_b};
            4'h5: res33 = {1'b0, op_a ^ op_b};
            4'h6: res33 = {1'b0, op_a} << shamt;
            4'h7: res33 = {shr_tmp[0], shr_tmp[32:1]};
            4'h8: res33 = {1'b0, op_a} + {1'b0, {{16{imm16[15]}}, imm16}};
            4'h9: begin res33 = {1'b0, imm16, 16'h0}; upd_flags = 1'b0; end
            4'hA: begin res33 = {1'b0, op_a | {16'h0, imm16}}; upd_flags = 1'b0; end
`ifdef EXEC_FLAGS_EN
            4'hB: res33 = {1'b0, op_a} + {1'b0, op_b} + {32'd0, flags[1]};
`endif
            default: begin
                wr_en     = 1'b0;
                keep_rd   = 1'b0;
                bad_op    = 1'b1;
                upd_flags = 1'b0;
            end
        endcase
    end

`ifndef EXEC_FLAGS_EN
    logic unused_flag_bits;
    assign unused_flag_bits = &{1'b0, res33[32], upd_flags};
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = OUT;
            OUT:     if (ack_to_EX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed       <= 1'b1;
            ack_from_EX <= 1'b0;
            DOR         <= 1'b0;
            data_out    <= '0;
            result_rd   <= '0;
            illegal     <= 1'b0;
            instr       <= '0;
            // NOTE: the register file must read as zero after reset, so every entry
            // is cleared here; this forces flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef EXEC_FLAGS_EN
            flags       <= '0;
`endif
        end else begin
            illegal <= 1'b0;
            // Re-arm only after DIR has been seen low, so a held word is taken once.
            if (!DIR) armed <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    instr       <= data_in;
                    ack_from_EX <= 1'b1;
                    armed       <= 1'b0;
                end
                EXEC: begin
                    ack_from_EX <= 1'b0;
                    DOR         <= 1'b1;
                    data_out    <= result;
                    result_rd   <= keep_rd ? rd : 4'd0;
                    illegal     <= bad_op;
                    if (wr_en && rd != 4'd0) regs[rd] <= result;
`ifdef EXEC_FLAGS_EN
                    if (upd_flags) flags <= {res33[32], result == 32'd0};
`endif
                end
                OUT: if (ack_to_EX) DOR <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_execute.sv
// Table-driven bench for instruction_execute; builds with or without EXEC_FLAGS_EN.
module tb_instruction_execute;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic [3:0]  rd;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, DIR, ack_from_EX, DOR, ack_to_EX, illegal;
    logic [31:0] data_in, data_out;
    logic [3:0]  result_rd;
`ifdef EXEC_FLAGS_EN
    logic [1:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    instruction_execute dut (
        .clk(clk), .reset(reset), .DIR(DIR), .ack_from_EX(ack_from_EX),
        .data_in(data_in), .DOR(DOR), .ack_to_EX(ack_to_EX),
        .data_out(data_out), .result_rd(result_rd), .illegal(illegal)
`ifdef EXEC_FLAGS_EN
        , .flags(flags)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one word through the full handshake and check every phase.
    task automatic run_instr(input vec_t v, input int hold, input bit keep_dir);
        bit    seen = 1'b0;
        string tag  = $sformatf("%h", v.instr);
        @(negedge clk);
        DIR = 1'b1; data_in = v.instr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_from_EX) begin seen = 1'b1; break; end
        end
        check({"accept ", tag}, {31'd0, seen}, 32'd1);
        if (!seen) begin DIR = 1'b0; return; end
        check({"dor_low_at_accept ", tag}, {31'd0, DOR}, 32'd0);
        if (!keep_dir) DIR = 1'b0;
        @(negedge clk);
        check({"ack_pulse_end ", tag}, {31'd0, ack_from_EX}, 32'd0);
        check({"dor ", tag}, {31'd0, DOR}, 32'd1);
        check({"data ", tag}, data_out, v.data);
        check({"rd ", tag}, {28'd0, result_rd}, {28'd0, v.rd});
        check({"illegal ", tag}, {31'd0, illegal}, {31'd0, v.ill});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({"dor_hold ", tag}, {31'd0, DOR}, 32'd1);
            check({"data_hold ", tag}, data_out, v.data);
            check({"rd_hold ", tag}, {28'd0, result_rd}, {28'd0, v.rd});
            check({"illegal_end ", tag}, {31'd0, illegal}, 32'd0);
        end
        ack_to_EX = 1'b1;
        @(negedge clk);
        ack_to_EX = 1'b0;
        check({"dor_drop ", tag}, {31'd0, DOR}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " dor"}, {31'd0, DOR}, 32'd0);
        check({name, " ack"}, {31'd0, ack_from_EX}, 32'd0);
        check({name, " data"}, data_out, 32'd0);
        check({name, " rd"}, {28'd0, result_rd}, 32'd0);
        check({name, " illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        int acks;
        vecs.push_back('{32'h91001234, 32'h12340000, 4'd1,  1'b0}); // LUI r1
        vecs.push_back('{32'h9100FFFF, 32'hFFFF0000, 4'd1,  1'b0}); // LUI r1
        vecs.push_back('{32'hA110FFFF, 32'hFFFFFFFF, 4'd1,  1'b0}); // ORI r1
        vecs.push_back('{32'h82100001, 32'h00000000, 4'd2,  1'b0}); // ADDI wraps to 0
        vecs.push_back('{32'h85000005, 32'h00000005, 4'd5,  1'b0}); // r5 = 5
        vecs.push_back('{32'h10550000, 32'h0000000A, 4'd0,  1'b0}); // ADD r0 dropped
        vecs.push_back('{32'h43000000, 32'h00000000, 4'd3,  1'b0}); // OR r3,r0,r0
        vecs.push_back('{32'h26050000, 32'hFFFFFFFB, 4'd6,  1'b0}); // SUB 0-5
        vecs.push_back('{32'h37150000, 32'h00000005, 4'd7,  1'b0}); // AND
        vecs.push_back('{32'h58150000, 32'hFFFFFFFA, 4'd8,  1'b0}); // XOR
        vecs.push_back('{32'h69550000, 32'h000000A0, 4'd9,  1'b0}); // SHL by 5
        vecs.push_back('{32'h7A150000, 32'h07FFFFFF, 4'd10, 1'b0}); // SHR by 5
        vecs.push_back('{32'h8B00FFFF, 32'hFFFFFFFF, 4'd11, 1'b0}); // ADDI -1
        vecs.push_back('{32'h6C5B0000, 32'h80000000, 4'd12, 1'b0}); // SHL by 31
        vecs.push_back('{32'h0ABC1234, 32'h00000000, 4'd0,  1'b0}); // NOP
        vecs.push_back('{32'hC5150000, 32'h00000000, 4'd0,  1'b1}); // reserved, rd=r5
        vecs.push_back('{32'h4D500000, 32'h00000005, 4'd13, 1'b0}); // r5 unchanged
`ifdef EXEC_FLAGS_EN
        vecs.push_back('{32'hBE550000, 32'h0000000A, 4'd14, 1'b0}); // ADC, carry=0
`else
        vecs.push_back('{32'hBE550000, 32'h00000000, 4'd0,  1'b1}); // B reserved
`endif
        vecs.push_back('{32'h1F150000, 32'h00000004, 4'd15, 1'b0}); // ADD wraps

        reset = 1'b1; DIR = 1'b0; ack_to_EX = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
`ifdef EXEC_FLAGS_EN
        check("reset flags", {30'd0, flags}, 32'd0);
`endif
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i], (i == 0) ? 5 : 1, 1'b0);
`ifdef EXEC_FLAGS_EN
            if (vecs[i].instr == 32'h82100001) check("flags addi", {30'd0, flags}, 32'd3);
`endif
        end

        // DIR held high: exactly one acceptance until DIR is seen low.
        run_instr('{32'h85500001, 32'h00000006, 4'd5, 1'b0}, 1, 1'b1);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_from_EX) acks++;
        end
        check("no_double_accept", acks, 0);
        check("no_double_dor", {31'd0, DOR}, 32'd0);
        DIR = 1'b0;
        run_instr('{32'h85500001, 32'h00000007, 4'd5, 1'b0}, 1, 1'b0);

        // Reset while in OUT discards the result and clears the register file.
        @(negedge clk);
        DIR = 1'b1; data_in = 32'h43100000;
        @(negedge clk);
        DIR = 1'b0;
        @(negedge clk);
        check("pre_reset dor", {31'd0, DOR}, 32'd1);
        check("pre_reset data", data_out, 32'hFFFFFFFF);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        run_instr('{32'h43100000, 32'h00000000, 4'd3, 1'b0}, 1, 1'b0);
        run_instr('{32'h43500000, 32'h00000000, 4'd3, 1'b0}, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
